fib_job_sequencer: RTL and testbench

Initiator-side controller for the single-Fibonacci engine. It buffers Fibonacci job requests from upstream in a small FIFO and launches each job on the engine with a one-cycle start pulse plus operand. It then tracks the engine's busy flag until the job completes, captures the result and hands it downstream with a valid/ready handshake. It also keeps a running wrap-around total of all results, replacing the purely combinational two-engine summing with a sequenced, back-pressured job stream.

---
 rtl/fib_pkg.sv | 22 ++
 rtl/fib_job_fifo.sv | 57 +++++
 rtl/fib_job_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fib_job_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: shared types and constants for the Fibonacci job sequencer.
// Provides the sequencer FSM state enum, the default data width and the
// helper that sizes the job timeout counter.
package fib_pkg;

  localparam int FIB_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_RISE,
    WAIT_FALL,
    EMIT
  } fsm_state_e;

  // Width of a counter that must reach TIMEOUT-2 (the last value before the
  // abort fires); at least one bit so tiny TIMEOUT values still elaborate.
  function automatic int tmo_cnt_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/fib_job_fifo.sv
// fib_job_fifo: DEPTH x WIDTH job queue, first-word-fall-through read.
// Ports: clk_i/rst_ni, push_i+push_dat_i write, pop_i consumes head_dat_o,
//        full_o/empty_o status. Push when full and pop when empty are ignored.
module fib_job_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/fib_job_sequencer.sv
// fib_job_sequencer: queues Fibonacci jobs, launches each on the engine with a
// start pulse, waits on eng_busy (with timeout), returns the result over a
// valid/ready port and keeps a wrapping running total with sticky overflow.
// Ports: req_* job input (req_ready = FIFO not full), eng_* engine side,
//        res_* result output, total/total_ovf/total_clr accumulator.
module fib_job_sequencer
  import fib_pkg::*;
#(
  parameter int WIDTH   = FIB_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset_button_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a0,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_a0,
  input  logic             eng_busy,
  input  logic [WIDTH-1:0] eng_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic [WIDTH-1:0] total,
  output logic             total_ovf,
  input  logic             total_clr
);

  localparam int CW = tmo_cnt_width(TIMEOUT);
  // The counter is cleared in LAUNCH and counts every wait cycle. Aborting
  // when the count about to be written is TIMEOUT-1 puts res_valid exactly
  // TIMEOUT cycles after the start pulse.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 2);

  fsm_state_e       state_q, state_d;
  logic [CW-1:0]    tmo_q, tmo_d;
  logic [WIDTH-1:0] eng_a0_q, eng_a0_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic [WIDTH-1:0] total_q, total_d;
  logic             ovf_q, ovf_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_head;
  logic             tmo_hit;
  logic             res_hs;
  logic [WIDTH:0]   sum;

  // Full depends only on registered pointers, so no input reaches req_ready.
  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && !fifo_full;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  fib_job_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (reset_button_n),
    .push_i     (fifo_push),
    .push_dat_i (req_a0),
    .pop_i      (fifo_pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign tmo_hit = (tmo_q == TMO_LAST);
  assign res_hs  = (state_q == EMIT) && res_ready;
  assign sum     = {1'b0, total_q} + {1'b0, res_data_q};

  // State register
  always_ff @(posedge clk or negedge reset_button_n) begin
    if (!reset_button_n) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Next-state logic; timeout wins over a same-cycle busy edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!fifo_empty) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_RISE;
      WAIT_RISE: begin
        if (tmo_hit)       state_d = EMIT;
        else if (eng_busy) state_d = WAIT_FALL;
      end
      WAIT_FALL: begin
        if (tmo_hit || !eng_busy) state_d = EMIT;
      end
      EMIT:      if (res_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    eng_start = (state_q == LAUNCH);
    res_valid = (state_q == EMIT);
  end

  // Datapath next-state
  always_comb begin
    tmo_d      = tmo_q;
    eng_a0_d   = eng_a0_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    total_d    = total_q;
    ovf_d      = ovf_q;

    if (fifo_pop) eng_a0_d = fifo_head;

    case (state_q)
      LAUNCH: tmo_d = '0;
      WAIT_RISE, WAIT_FALL: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_hit) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
        end else if (state_q == WAIT_FALL && !eng_busy) begin
          res_data_d = eng_result;
          res_err_d  = 1'b0;
        end
      end
      default: ;
    endcase

    // Clear beats a same-cycle accumulate; the add is simply dropped.
    if (total_clr) begin
      total_d = '0;
      ovf_d   = 1'b0;
    end else if (res_hs && !res_err_q) begin
      total_d = sum[WIDTH-1:0];
      ovf_d   = ovf_q | sum[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_button_n) begin
    if (!reset_button_n) begin
      tmo_q      <= '0;
      eng_a0_q   <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      total_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      eng_a0_q   <= eng_a0_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      total_q    <= total_d;
      ovf_q      <= ovf_d;
    end
  end

  assign eng_a0    = eng_a0_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign total     = total_q;
  assign total_ovf = ovf_q;

endmodule

// File: tb/tb_fib_job_sequencer.sv
// Bench for fib_job_sequencer (WIDTH=8, DEPTH=4, TIMEOUT=16): directed jobs,
// a behavioural engine, and a result scoreboard checked by a separate monitor.
module tb_fib_job_sequencer;

  logic       clk;
  logic       reset_button_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a0;
  logic       eng_start;
  logic [7:0] eng_a0;
  logic       eng_busy;
  logic [7:0] eng_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;
  logic [7:0] total;
  logic       total_ovf;
  logic       total_clr;

  fib_job_sequencer #(
    .WIDTH   (8),
    .DEPTH   (4),
    .TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .reset_button_n (reset_button_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a0         (req_a0),
    .eng_start      (eng_start),
    .eng_a0         (eng_a0),
    .eng_busy       (eng_busy),
    .eng_result     (eng_result),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_err        (res_err),
    .total          (total),
    .total_ovf      (total_ovf),
    .total_clr      (total_clr)
  );

  typedef struct {
    logic [7:0] a0;
    int         rise;
    int         hold;
    logic [7:0] res;
    bit         never;
  } job_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  job_t job_q[$];
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endfunction

  // Start pulse counter
  initial begin
    forever begin
      @(negedge clk);
      if (eng_start) n_start++;
    end
  end

  // Engine model: on each start, check the operand, then raise busy after
  // 'rise' cycles and drop it 'hold' cycles later with the configured result.
  initial begin
    job_t j;
    bit   abort;
    eng_busy   = 1'b0;
    eng_result = '0;
    forever begin
      @(posedge clk); #1;
      if (reset_button_n && eng_start) begin
        if (job_q.size() == 0) begin
          chk(1'b0, "unexpected_start", 32'(eng_a0), 32'(0));
        end else begin
          j = job_q.pop_front();
          chk(eng_a0 == j.a0, "eng_a0", 32'(eng_a0), 32'(j.a0));
          if (!j.never) begin
            abort = 1'b0;
            repeat (j.rise) @(posedge clk);
            #1 eng_busy = 1'b1;
            for (int k = 0; k < j.hold && !abort; k++) begin
              @(posedge clk); #1;
              if (!reset_button_n) abort = 1'b1;
            end
            eng_result = j.res;
            eng_busy   = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard monitor: compare every accepted result with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_button_n && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_result", 32'(res_data), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk(res_data == e.data, "res_data", 32'(res_data), 32'(e.data));
          chk(res_err == e.err, "res_err", 32'(res_err), 32'(e.err));
        end
      end
    end
  end

  // Called at #1 after a posedge; returns at #1 after the accepting edge.
  task automatic issue(input logic [7:0] a0, input int rise, input int hold,
                       input logic [7:0] res, input bit never);
    int n;
    job_q.push_back('{a0, rise, hold, res, never});
    exp_q.push_back('{never ? 8'd0 : res, never});
    req_valid = 1'b1;
    req_a0    = a0;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk(1'b0, "push_timeout", 32'(n), 32'(200));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || job_q.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n < 400, name, 32'(n), 32'(400));
  endtask

  task automatic wait_res_valid(input string name);
    int n;
    n = 0;
    while (!res_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n < 200, name, 32'(n), 32'(200));
  endtask

  task automatic pulse_clr();
    total_clr = 1'b1;
    @(posedge clk); #1;
    total_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int s0;
    int n;
    reset_button_n = 1'b0;
    req_valid      = 1'b0;
    req_a0         = '0;
    res_ready      = 1'b1;
    total_clr      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk(req_ready == 1'b1, "rst_req_ready", 32'(req_ready), 32'(1));
    chk(eng_start == 1'b0, "rst_eng_start", 32'(eng_start), 32'(0));
    chk(eng_a0 == 8'd0, "rst_eng_a0", 32'(eng_a0), 32'(0));
    chk(res_valid == 1'b0, "rst_res_valid", 32'(res_valid), 32'(0));
    chk(res_data == 8'd0, "rst_res_data", 32'(res_data), 32'(0));
    chk(res_err == 1'b0, "rst_res_err", 32'(res_err), 32'(0));
    chk(total == 8'd0, "rst_total", 32'(total), 32'(0));
    chk(total_ovf == 1'b0, "rst_total_ovf", 32'(total_ovf), 32'(0));
    reset_button_n = 1'b1;
    @(posedge clk); #1;

    // Single job: a0=8 -> 21
    issue(8'd8, 2, 10, 8'd21, 1'b0);
    wait_drain("single_drain");
    chk(n_start == 1, "single_starts", 32'(n_start), 32'(1));
    chk(total == 8'd21, "single_total", 32'(total), 32'(21));

    // FIFO fill: first job keeps the engine busy while four more queue up
    pulse_clr();
    chk(total == 8'd0, "clr_total", 32'(total), 32'(0));
    issue(8'd1, 2, 10, 8'd1, 1'b0);
    issue(8'd2, 1, 2, 8'd1, 1'b0);
    issue(8'd3, 1, 2, 8'd2, 1'b0);
    issue(8'd4, 1, 2, 8'd3, 1'b0);
    issue(8'd5, 1, 2, 8'd5, 1'b0);
    chk(req_ready == 1'b0, "fill_full", 32'(req_ready), 32'(0));
    wait_drain("fill_drain");
    chk(total == 8'd12, "fill_total", 32'(total), 32'(12));
    chk(eng_a0 == 8'd5, "fill_eng_a0_hold", 32'(eng_a0), 32'(5));

    // Backpressure: hold res_ready low for 20 cycles
    res_ready = 1'b0;
    s0 = n_start;
    issue(8'd6, 1, 3, 8'd8, 1'b0);
    issue(8'd7, 1, 3, 8'd13, 1'b0);
    wait_res_valid("bp_valid_wait");
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk(res_valid && res_data == 8'd8, "bp_hold", 32'(res_data), 32'(8));
    end
    chk(n_start - s0 == 1, "bp_starts", 32'(n_start - s0), 32'(1));
    res_ready = 1'b1;
    wait_drain("bp_drain");
    chk(total == 8'd33, "bp_total", 32'(total), 32'(33));

    // Timeout: engine never responds
    issue(8'd9, 0, 0, 8'd0, 1'b1);
    n = 0;
    while (!eng_start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n < 50, "tmo_start_wait", 32'(n), 32'(50));
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n == 16, "tmo_latency", 32'(n), 32'(16));
    wait_drain("tmo_drain");
    chk(total == 8'd33, "tmo_total", 32'(total), 32'(33));

    // Overflow and clear
    pulse_clr();
    issue(8'd10, 1, 2, 8'd200, 1'b0);
    issue(8'd11, 1, 2, 8'd100, 1'b0);
    wait_drain("ovf_drain");
    chk(total == 8'd44, "ovf_total", 32'(total), 32'(44));
    chk(total_ovf == 1'b1, "ovf_flag", 32'(total_ovf), 32'(1));
    res_ready = 1'b0;
    issue(8'd12, 1, 2, 8'd5, 1'b0);
    wait_res_valid("clr_valid_wait");
    total_clr = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    total_clr = 1'b0;
    chk(total == 8'd0, "clr_hs_total", 32'(total), 32'(0));
    chk(total_ovf == 1'b0, "clr_hs_ovf", 32'(total_ovf), 32'(0));
    wait_drain("clr_drain");

    // Reset in the middle of WAIT_FALL
    issue(8'd4, 1, 8, 8'd3, 1'b0);
    n = 0;
    while (!eng_busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n < 50, "rst_busy_wait", 32'(n), 32'(50));
    repeat (2) @(posedge clk);
    #1 reset_button_n = 1'b0;
    #1;
    chk(eng_start == 1'b0, "mid_rst_eng_start", 32'(eng_start), 32'(0));
    chk(eng_a0 == 8'd0, "mid_rst_eng_a0", 32'(eng_a0), 32'(0));
    chk(res_valid == 1'b0, "mid_rst_res_valid", 32'(res_valid), 32'(0));
    chk(req_ready == 1'b1, "mid_rst_req_ready", 32'(req_ready), 32'(1));
    chk(total == 8'd0, "mid_rst_total", 32'(total), 32'(0));
    exp_q.delete();
    job_q.delete();
    repeat (3) @(posedge clk);
    #1 reset_button_n = 1'b1;
    @(posedge clk); #1;
    issue(8'd3, 1, 3, 8'd2, 1'b0);
    wait_drain("post_rst_drain");
    chk(total == 8'd2, "post_rst_total", 32'(total), 32'(2));
    chk(eng_a0 == 8'd3, "post_rst_eng_a0", 32'(eng_a0), 32'(3));

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
